serial_slave_burst: RTL and testbench
=====================================

// Module: serial_slave_burst
// PURPOSE
//  Parametrised serial-bus slave, next generation of the single-lane slave.
//  - Decodes a serial control frame, then serves single or multi-word read/write bursts to a local RAM.
//  - Data moves over LANES parallel serial lanes; the burst length is carried in the frame.
//  - Sits behind the interconnect, one instance per slave ID.
// PARAMETERS
//  ADDR_DEPTH     2048  RAM words
//  DATA_WIDTH     32    word width; must be a multiple of LANES
//  LANES          1     serial data lanes on wD/rD (1,2,4,8)
//  SLAVES         3     slaves on bus
//  S_ID_WIDTH     $clog2(SLAVES+1)  slave ID field width
//  SLAVE_ID       1     this slave's ID
//  LEN_WIDTH      4     burst-length field width
//  MEM_INIT_FILE  ""    $readmemh image; empty = no init
//  Derived:
//    AW = $clog2(ADDR_DEPTH)
//    BEATS = DATA_WIDTH/LANES
//    CFG_LEN = 3+S_ID_WIDTH+1+LEN_WIDTH+AW
// PORTS
//  clk      in   1      clock
//  rstN     in   1      async active-low reset
//  control  in   1      serial control frame, MSB first
//  wD       in   LANES  write data, MSB-first beats
//  valid    in   1      master beat valid (writes)
//  last     in   1      master early burst termination
//  rD       out  LANES  read data beats
//  ready    out  1      slave ready / read-beat valid
//  err      out  1      1-cycle pulse on rejected frame
// BEHAVIOUR
//  Reset and clocking:
//  - One clock (clk); reset is asynchronous and active-low (rstN).
//  - On reset: state=IDLE, rD=0, ready=1, err=0, all counters 0. RAM contents are not cleared.
//  - Reset mid-burst aborts immediately. A partially shifted write word is discarded.
//  Control frame:
//  - Fields, MSB first: 3'b111 | id[S_ID_WIDTH] | rw (1=write) | len[LEN_WIDTH] | addr[AW].
//  - The burst is len+1 words; len=0 is a single word.
//  States: IDLE, CFG, DECODE, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT.
//  - IDLE: ready=1. control==1 captures bit 0 of the frame -> CFG.
//  - CFG: captures one control bit per cycle. After CFG_LEN bits total -> DECODE.
//  - DECODE (1 cycle):
//      start!=111 or id!=SLAVE_ID -> IDLE silently.
//      addr>=ADDR_DEPTH -> err=1 for one cycle -> IDLE.
//      Otherwise: read -> RD_LOAD; write -> WR_SHIFT.
//  - RD_LOAD (1 cycle): ready=0; shift register <= ram[addr] -> RD_SHIFT.
//  - RD_SHIFT: ready=1; rD = top LANES bits; shift left by LANES each cycle.
//      After BEATS cycles:
//        words_done==len, or last sampled high during this word -> IDLE.
//        Otherwise addr++ -> RD_LOAD.
//  - WR_SHIFT: ready=1.
//      Each cycle with valid=1 shifts wD into the LSBs.
//      valid=0 stalls with no shift and no timeout.
//      After BEATS accepted beats -> WR_COMMIT.
//  - WR_COMMIT (1 cycle): ready=0; ram[addr] <= shift register.
//      Then: words_done==len, or last seen with any beat of this word -> IDLE.
//      Otherwise addr++ -> WR_SHIFT.
//  Read latency: first rD beat appears 2 cycles after the last frame bit (DECODE, RD_LOAD).
//  Boundaries and rules:
//  - Address wraps ADDR_DEPTH-1 -> 0 inside a burst. This holds for non-power-of-2 depth too.
//  - last on the final beat with words_done<len ends the burst early; the current word is still committed.
//  - control activity outside IDLE is ignored. No frame nesting.
//  - A read from an address written in the previous burst returns the new data (no stale bypass).
//  - Word counter is LEN_WIDTH bits, with no overflow at len = all-ones.
//  - rD = 0 whenever the state is not RD_SHIFT.
// TESTING
//  1. LANES=1: write frame id=1, len=0, addr=5, data 0xA5A5_0F0F.
//     Then read addr 5 -> 32 rD beats MSB first = 0xA5A5_0F0F; ready low exactly in RD_LOAD.
//  2. LANES=4: write burst len=3 at addr ADDR_DEPTH-2, words 1,2,3,4.
//     Read back -> ram[2046]=1, ram[2047]=2, ram[0]=3, ram[1]=4 (wrap).
//  3. Write with valid toggling every other cycle -> word commits only after 32 valid beats.
//     Stalled cycles shift nothing.
//  4. Read burst len=7 with last high during word 2 -> exactly 3 words output, then IDLE, ready=1.
//  5. Frame with id=2 -> no ready drop and no err. Frame with addr>=ADDR_DEPTH -> err pulse of 1 cycle.
//  6. Assert rstN low mid-WR_SHIFT -> rD=0, ready=1 at once; target word unchanged.
//     Next frame decodes normally.

Source files
------------

// File: rtl/serial_slave_burst.sv
// Serial-bus slave: frame decode plus multi-lane read/write bursts
// against a local word RAM, one instance per slave ID.
module serial_slave_burst #(
  parameter int    ADDR_DEPTH    = 2048,
  parameter int    DATA_WIDTH    = 32,
  parameter int    LANES         = 1,
  parameter int    SLAVES        = 3,
  parameter int    S_ID_WIDTH    = $clog2(SLAVES+1),
  parameter int    SLAVE_ID      = 1,
  parameter int    LEN_WIDTH     = 4,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             control,
  input  logic [LANES-1:0] wD,
  input  logic             valid,
  input  logic             last,
  output logic [LANES-1:0] rD,
  output logic             ready,
  output logic             err
);

  localparam int AW      = $clog2(ADDR_DEPTH);
  localparam int DW      = DATA_WIDTH;
  localparam int BEATS   = DATA_WIDTH / LANES;
  localparam int CFG_LEN = 3 + S_ID_WIDTH + 1 + LEN_WIDTH + AW;
  localparam int BCW     = $clog2(CFG_LEN + 1);
  localparam int BTW     = $clog2(BEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_DECODE,
    S_RD_LOAD,
    S_RD_SHIFT,
    S_WR_SHIFT,
    S_WR_COMMIT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CFG_LEN-1:0]   r_frame;
  logic [BCW-1:0]       r_bitcnt;
  logic [DW-1:0]        r_sr;
  logic [BTW-1:0]       r_beat;
  logic [LEN_WIDTH-1:0] r_words;
  logic [LEN_WIDTH-1:0] r_len;
  logic [AW-1:0]        r_addr;
  logic                 r_last;
  logic [DW-1:0]        r_mem [ADDR_DEPTH];

  logic [CFG_LEN-1:0]    w_frame_nxt;
  logic [2:0]            w_start;
  logic [S_ID_WIDTH-1:0] w_id;
  logic                  w_rw;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [AW-1:0]         w_faddr;
  logic                  w_id_ok;
  logic                  w_addr_bad;
  logic [AW-1:0]         w_addr_inc;
  logic                  w_beat_end;
  logic                  w_rd_stop;
  logic                  w_wr_stop;
  logic                  w_ready;
  logic                  w_err;
  logic [LANES-1:0]      w_rd;

  assign w_frame_nxt = {r_frame[CFG_LEN-2:0], control};
  assign w_start     = r_frame[CFG_LEN-1 -: 3];
  assign w_id        = r_frame[CFG_LEN-4 -: S_ID_WIDTH];
  assign w_rw        = r_frame[AW+LEN_WIDTH];
  assign w_len       = r_frame[AW+LEN_WIDTH-1 -: LEN_WIDTH];
  assign w_faddr     = r_frame[AW-1:0];

  assign w_id_ok    = (w_start == 3'b111) &&
                      (w_id == S_ID_WIDTH'(SLAVE_ID));
  assign w_addr_bad = (32'(w_faddr) >= 32'(ADDR_DEPTH));

  // explicit wrap so non-power-of-2 depths stay in range
  assign w_addr_inc = (r_addr == AW'(ADDR_DEPTH-1)) ?
                      '0 : r_addr + AW'(1);

  assign w_beat_end = (r_beat == BTW'(BEATS-1));
  assign w_rd_stop  = (r_words == r_len) || r_last || last;
  assign w_wr_stop  = (r_words == r_len) || r_last;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_err       = 1'b0;
    w_rd        = '0;
    unique case (r_state)
      S_IDLE: begin
        if (control) w_state_nxt = S_CFG;
      end
      S_CFG: begin
        if (r_bitcnt == BCW'(CFG_LEN-1))
          w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!w_id_ok) begin
          w_state_nxt = S_IDLE;
        end else if (w_addr_bad) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rw) begin
          w_state_nxt = S_WR_SHIFT;
        end else begin
          w_state_nxt = S_RD_LOAD;
        end
      end
      S_RD_LOAD: begin
        w_ready     = 1'b0;
        w_state_nxt = S_RD_SHIFT;
      end
      S_RD_SHIFT: begin
        w_rd = r_sr[DW-1 -: LANES];
        if (w_beat_end)
          w_state_nxt = w_rd_stop ? S_IDLE : S_RD_LOAD;
      end
      S_WR_SHIFT: begin
        if (valid && w_beat_end)
          w_state_nxt = S_WR_COMMIT;
      end
      S_WR_COMMIT: begin
        w_ready     = 1'b0;
        w_state_nxt = w_wr_stop ? S_IDLE : S_WR_SHIFT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_frame  <= '0;
      r_bitcnt <= '0;
      r_sr     <= '0;
      r_beat   <= '0;
      r_words  <= '0;
      r_len    <= '0;
      r_addr   <= '0;
      r_last   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (control) begin
            r_frame  <= w_frame_nxt;
            r_bitcnt <= BCW'(1);
          end
        end
        S_CFG: begin
          r_frame  <= w_frame_nxt;
          r_bitcnt <= r_bitcnt + BCW'(1);
        end
        S_DECODE: begin
          r_addr   <= w_faddr;
          r_len    <= w_len;
          r_words  <= '0;
          r_beat   <= '0;
          r_last   <= 1'b0;
          r_bitcnt <= '0;
        end
        S_RD_LOAD: begin
          r_sr   <= r_mem[r_addr];
          r_beat <= '0;
          r_last <= 1'b0;
        end
        S_RD_SHIFT: begin
          r_sr   <= r_sr << LANES;
          r_beat <= r_beat + BTW'(1);
          if (last) r_last <= 1'b1;
          if (w_beat_end && !w_rd_stop) begin
            r_addr  <= w_addr_inc;
            r_words <= r_words + LEN_WIDTH'(1);
          end
        end
        S_WR_SHIFT: begin
          if (valid) begin
            r_sr   <= (r_sr << LANES) | DW'(wD);
            r_beat <= r_beat + BTW'(1);
            if (last) r_last <= 1'b1;
          end
        end
        S_WR_COMMIT: begin
          r_beat <= '0;
          if (!w_wr_stop) begin
            r_addr  <= w_addr_inc;
            r_words <= r_words + LEN_WIDTH'(1);
            r_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM content survives reset
  always_ff @(posedge clk) begin
    if (r_state == S_WR_COMMIT) r_mem[r_addr] <= r_sr;
  end

  assign rD    = w_rd;
  assign ready = w_ready;
  assign err   = w_err;

endmodule

// File: tb/tb_serial_slave_burst.sv
// Randomized bench for serial_slave_burst with a word-array model
// of the RAM and burst rules (4 lanes, 2000-word non-power-of-2 RAM).
module tb_serial_slave_burst;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2000;
  localparam int BEATS = DW / LANES;
  localparam int FL    = 21;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       control = 1'b0;
  logic [3:0] wD = '0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [3:0] rD;
  logic       ready;
  logic       err;

  int checks = 0;
  int passed = 0;

  logic [31:0] model [DEPTH];
  bit          known [DEPTH];

  serial_slave_burst #(
    .ADDR_DEPTH(DEPTH), .DATA_WIDTH(DW), .LANES(LANES),
    .SLAVES(3), .SLAVE_ID(1), .LEN_WIDTH(4), .MEM_INIT_FILE("")
  ) dut (
    .clk(clk), .rstN(rstN), .control(control), .wD(wD),
    .valid(valid), .last(last), .rD(rD), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [2:0] st, input int id,
                            input bit rw, input int len,
                            input int addr);
    logic [FL-1:0] f;
    f = {st, 2'(id), rw, 4'(len), 11'(addr)};
    for (int i = FL-1; i >= 0; i--) begin
      control = f[i];
      step();
    end
    control = 1'b0;
  endtask

  task automatic do_write(input int addr, input int len,
                          input int last_word, input int mode,
                          input bit fixed, input logic [31:0] seed);
    logic [31:0] w;
    int a, beats, cyc;
    bit v, ph;
    a = addr;
    send_frame(3'b111, 1, 1'b1, len, addr);
    checks++;
    if ({ready, err} !== 2'b10)
      $display("FAIL wr_decode ready/err=%b want 10", {ready, err});
    else passed++;
    step();
    for (int k = 0; k <= len; k++) begin
      w = fixed ? seed + 32'(k) : $urandom;
      beats = 0; cyc = 0; ph = 1'b0;
      while (beats < BEATS && cyc < 200) begin
        v = (mode == 0) ? 1'b1 :
            (mode == 1) ? ph : 1'($urandom_range(0, 1));
        ph = ~ph;
        valid = v;
        wD = v ? w[31-4*beats -: 4] : 4'($urandom);
        last = v && (k == last_word);
        control = 1'($urandom_range(0, 1));
        checks++;
        if (ready !== 1'b1)
          $display("FAIL wr_shift_ready word %0d beat %0d got %b want 1",
                   k, beats, ready);
        else passed++;
        if (v) beats++;
        cyc++;
        step();
      end
      valid = 1'b0; last = 1'b0; wD = '0;
      checks++;
      if (ready !== 1'b0)
        $display("FAIL wr_commit_ready word %0d got %b want 0", k, ready);
      else passed++;
      model[a] = w; known[a] = 1'b1;
      control = 1'($urandom_range(0, 1));
      step();
      if (k == last_word) break;
      a = (a + 1) % DEPTH;
    end
    control = 1'b0;
  endtask

  task automatic do_read(input int addr, input int len,
                         input int last_word, input int last_beat);
    logic [31:0] got;
    int a, n;
    a = addr;
    n = (last_word >= 0 && last_word <= len) ? last_word + 1 : len + 1;
    send_frame(3'b111, 1, 1'b0, len, addr);
    checks++;
    if ({ready, err, rD} !== 6'b10_0000)
      $display("FAIL rd_decode ready/err/rD=%b want 100000",
               {ready, err, rD});
    else passed++;
    step();
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({ready, rD} !== 5'b0_0000)
        $display("FAIL rd_load word %0d ready/rD=%b want 00000",
                 k, {ready, rD});
      else passed++;
      step();
      got = '0;
      for (int b = 0; b < BEATS; b++) begin
        checks++;
        if (ready !== 1'b1)
          $display("FAIL rd_shift_ready word %0d beat %0d got %b want 1",
                   k, b, ready);
        else passed++;
        got = {got[27:0], rD};
        last = (k == last_word) && (b == last_beat);
        control = 1'($urandom_range(0, 1));
        step();
      end
      last = 1'b0;
      if (known[a]) begin
        checks++;
        if (got !== model[a])
          $display("FAIL rd_data addr %0d got %h want %h", a, got, model[a]);
        else passed++;
      end
      a = (a + 1) % DEPTH;
    end
    control = 1'b0;
    checks++;
    if ({ready, rD} !== 5'b1_0000)
      $display("FAIL rd_end_idle ready/rD=%b want 10000", {ready, rD});
    else passed++;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({ready, err, rD} !== 6'b10_0000)
      $display("FAIL reset_outputs ready/err/rD=%b want 100000",
               {ready, err, rD});
    else passed++;
    rstN = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_write(5, 0, -1, 0, 1'b1, 32'hA5A5_0F0F);
    do_read(5, 0, -1, 0);
  endtask

  task automatic test_wrap();
    do_write(DEPTH-2, 3, -1, 0, 1'b1, 32'd1);
    do_read(DEPTH-2, 3, -1, 0);
  endtask

  task automatic test_stall();
    do_write(100, 0, -1, 1, 1'b0, 32'd0);
    do_write(101, 1, -1, 2, 1'b0, 32'd0);
    do_read(100, 1, -1, 0);
  endtask

  task automatic test_early_read();
    do_write(200, 7, -1, 0, 1'b0, 32'd0);
    do_read(200, 7, 2, 3);
    do_read(204, 3, 1, BEATS-1);
  endtask

  task automatic test_early_write();
    do_write(300, 3, -1, 0, 1'b0, 32'd0);
    do_write(300, 3, 1, 2, 1'b0, 32'd0);
    do_read(300, 3, -1, 0);
  endtask

  task automatic test_ignored();
    logic [2:0] st;
    int id;
    do_write(50, 0, -1, 0, 1'b1, 32'h1234_5678);
    for (int t = 0; t < 2; t++) begin
      st = (t == 0) ? 3'b111 : 3'b101;
      id = (t == 0) ? 2 : 1;
      send_frame(st, id, 1'b1, 0, 50);
      for (int c = 0; c < 12; c++) begin
        valid = 1'b1;
        wD = 4'($urandom);
        checks++;
        if ({ready, err} !== 2'b10)
          $display("FAIL ignored_frame %0d cyc %0d ready/err=%b want 10",
                   t, c, {ready, err});
        else passed++;
        step();
      end
      valid = 1'b0;
    end
    do_read(50, 0, -1, 0);
  endtask

  task automatic test_err();
    send_frame(3'b111, 1, 1'b0, 0, 2040);
    checks++;
    if ({ready, err} !== 2'b11)
      $display("FAIL err_pulse ready/err=%b want 11", {ready, err});
    else passed++;
    step();
    checks++;
    if ({ready, err} !== 2'b10)
      $display("FAIL err_one_cycle ready/err=%b want 10", {ready, err});
    else passed++;
    do_read(DEPTH-1, 0, -1, 0);
  endtask

  task automatic test_len_max();
    do_write(1990, 15, -1, 2, 1'b0, 32'd0);
    do_read(1990, 15, -1, 0);
  endtask

  task automatic test_reset_mid();
    do_write(500, 0, -1, 0, 1'b1, 32'h9ABC_DEF1);
    send_frame(3'b111, 1, 1'b1, 0, 500);
    step();
    for (int b = 0; b < 3; b++) begin
      valid = 1'b1; wD = 4'hF;
      step();
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({ready, err, rD} !== 6'b10_0000)
      $display("FAIL reset_mid_write ready/err/rD=%b want 100000",
               {ready, err, rD});
    else passed++;
    valid = 1'b0; wD = '0;
    step();
    rstN = 1'b1;
    step();
    send_frame(3'b111, 1, 1'b0, 0, 500);
    step(); step(); step(); step();
    checks++;
    if (rD === 4'h0)
      $display("FAIL rd_beat_nonzero got %h want nonzero", rD);
    else passed++;
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({ready, rD} !== 5'b1_0000)
      $display("FAIL reset_mid_read ready/rD=%b want 10000", {ready, rD});
    else passed++;
    step();
    rstN = 1'b1;
    step();
    do_read(500, 0, -1, 0);
  endtask

  task automatic test_random();
    int ad [6];
    int ln [6];
    for (int i = 0; i < 6; i++) begin
      ad[i] = $urandom_range(0, DEPTH-1);
      ln[i] = $urandom_range(0, 3);
      do_write(ad[i], ln[i], -1, 2, 1'b0, 32'd0);
    end
    for (int i = 0; i < 6; i++) do_read(ad[i], ln[i], -1, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_stall();
    test_early_read();
    test_early_write();
    test_ignored();
    test_err();
    test_len_max();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
